// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmit/receive blocks: the transmitter
// state enum, serial line levels and the legal ranges of the parameters.
//
// Configuration macro: UART_TX_PARITY_EN (enables the PARITY state in the
// transmitter; the enum always lists it so the encoding stays stable).
// ---------------------------------------------------------------------------
package uart_pkg;

  // Transmitter frame states, in the order they occur on the line
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_tx_state_t;

  // Serial line levels
  localparam logic UART_IDLE  = 1'b1;
  localparam logic UART_START = 1'b0;

  // Legal parameter ranges
  localparam int DATA_BITS_MIN    = 5;
  localparam int DATA_BITS_MAX    = 9;
  localparam int CLKS_PER_BIT_MIN = 2;
  localparam int STOP_BITS_MIN    = 1;
  localparam int STOP_BITS_MAX    = 2;

endpackage

// File: rtl/uart_baud_tick.sv
// ---------------------------------------------------------------------------
// uart_baud_tick
// Bit-time counter shared by the UART transmitter and receiver. Counts
// 0..CLKS_PER_BIT-1 and flags the last cycle of each bit time.
//
// Ports:
//   i_clock  - clock, rising edge
//   i_reset  - asynchronous active-high reset
//   i_clear  - synchronous clear; holds the counter at 0 while high
//   o_tick   - high during the last cycle of a bit time (count = CLKS_PER_BIT-1)
// ---------------------------------------------------------------------------
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_clear,
  output logic o_tick
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST_COUNT = CW'(CLKS_PER_BIT - 1);

  if (CLKS_PER_BIT < CLKS_PER_BIT_MIN) begin : gBadClksPerBit
    $error("uart_baud_tick: CLKS_PER_BIT must be at least 2");
  end

  logic [CW-1:0] count_q, count_d;

  // Wrapping at the last count means every new bit starts at 0 without
  // needing an explicit clear from the user on each bit boundary
  always_comb begin
    count_d = count_q;
    if (i_clear || (count_q == LAST_COUNT)) begin
      count_d = '0;
    end else begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign o_tick = (count_q == LAST_COUNT) && !i_clear;

endmodule

// File: rtl/uart_tx_frame.sv
// ---------------------------------------------------------------------------
// uart_tx_frame
// Parametrised UART transmitter. Serialises a word as start bit, DATA_BITS
// data bits LSB first, optional parity bit and STOP_BITS stop bits, each bit
// held for CLKS_PER_BIT clocks. Keeps the i_act/o_busy handshake of the
// older fixed 8-bit transmitter.
//
// Configuration macro: UART_TX_PARITY_EN
//   defined   - a parity bit follows the data (PARITY_ODD selects polarity)
//   undefined - data is followed directly by the stop bits
//
// Ports:
//   i_clock  - clock, rising edge
//   i_reset  - asynchronous active-high reset; aborts any frame in flight
//   i_data   - word to send, sampled only when a request is accepted
//   i_act    - send request, accepted when o_busy is low
//   o_signal - serial line, idle high
//   o_busy   - frame in progress; requests are dropped while high
//   o_done   - one-cycle pulse in the cycle after the last stop bit
// ---------------------------------------------------------------------------
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 1,
  parameter int PARITY_ODD   = 0
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic [DATA_BITS-1:0] i_data,
  input  logic                 i_act,
  output logic                 o_signal,
  output logic                 o_busy,
  output logic                 o_done
);

  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [BW-1:0] LAST_DATA_BIT = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] LAST_STOP_BIT = BW'(STOP_BITS - 1);

  if (DATA_BITS < DATA_BITS_MIN || DATA_BITS > DATA_BITS_MAX) begin : gBadDataBits
    $error("uart_tx_frame: DATA_BITS must be 5..9");
  end
  if (STOP_BITS < STOP_BITS_MIN || STOP_BITS > STOP_BITS_MAX) begin : gBadStopBits
    $error("uart_tx_frame: STOP_BITS must be 1 or 2");
  end
  if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : gBadParityOdd
    $error("uart_tx_frame: PARITY_ODD must be 0 or 1");
  end

  uart_tx_state_t       state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [BW-1:0]        bitCnt_q, bitCnt_d;
  logic                 signal_q, signal_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 frameEnd;
  logic                 baudClear;
  logic                 bitTick;
`ifdef UART_TX_PARITY_EN
  logic                 parity_q, parity_d;
`endif

  // Bit timing: the counter is held at 0 while idle, so the first bit of a
  // frame starts counting from 0 in the cycle right after acceptance
  assign baudClear = (state_q == IDLE);

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) baudTick (
    .i_clock(i_clock),
    .i_reset(i_reset),
    .i_clear(baudClear),
    .o_tick (bitTick)
  );

  // State register; outputs are registered too so nothing combinational
  // reaches the pins
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q  <= IDLE;
      shift_q  <= '0;
      bitCnt_q <= '0;
      signal_q <= UART_IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      bitCnt_q <= bitCnt_d;
      signal_q <= signal_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  // Next-state logic. The bit counter counts data bits in DATA and stop
  // bits in STOP, and is zeroed on every state change. Parity is computed
  // from the word at acceptance since the shift register is consumed.
  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    bitCnt_d = bitCnt_q;
    frameEnd = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d = parity_q;
`endif
    case (state_q)
      IDLE: begin
        if (i_act) begin
          state_d  = START;
          shift_d  = i_data;
          bitCnt_d = '0;
`ifdef UART_TX_PARITY_EN
          parity_d = (^i_data) ^ 1'(PARITY_ODD);
`endif
        end
      end
      START: begin
        if (bitTick) begin
          state_d  = DATA;
          bitCnt_d = '0;
        end
      end
      DATA: begin
        if (bitTick) begin
          shift_d = {1'b1, shift_q[DATA_BITS-1:1]};
          if (bitCnt_q == LAST_DATA_BIT) begin
            bitCnt_d = '0;
`ifdef UART_TX_PARITY_EN
            state_d  = PARITY;
`else
            state_d  = STOP;
`endif
          end else begin
            bitCnt_d = bitCnt_q + 1'b1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bitTick) begin
          state_d  = STOP;
          bitCnt_d = '0;
        end
      end
`endif
      STOP: begin
        if (bitTick) begin
          if (bitCnt_q == LAST_STOP_BIT) begin
            state_d  = IDLE;
            bitCnt_d = '0;
            frameEnd = 1'b1;
          end else begin
            bitCnt_d = bitCnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d  = IDLE;
        bitCnt_d = '0;
      end
    endcase
  end

  // Output logic, decoded from the next state so the registered outputs
  // line up with the state they describe
  always_comb begin
    signal_d = UART_IDLE;
    case (state_d)
      IDLE:   signal_d = UART_IDLE;
      START:  signal_d = UART_START;
      DATA:   signal_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      PARITY: signal_d = parity_d;
`endif
      STOP:   signal_d = UART_IDLE;
      default: signal_d = UART_IDLE;
    endcase
    busy_d = (state_d != IDLE);
    done_d = frameEnd;
  end

  assign o_signal = signal_q;
  assign o_busy   = busy_q;
  assign o_done   = done_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_frame
// Directed testbench for uart_tx_frame. Two instances at CLKS_PER_BIT=4:
// A is 8 data bits / 1 stop / even parity, B is 7 data bits / 2 stops /
// odd parity. Expected frames are built from the word by a small model.
// Inputs are driven and outputs sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_uart_tx_frame;

  localparam int CPB = 4;

`ifdef UART_TX_PARITY_EN
  localparam int FRAME_A = 44;
  localparam int FRAME_B = 44;
`else
  localparam int FRAME_A = 40;
  localparam int FRAME_B = 40;
`endif

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] dataA;
  logic       actA;
  logic       sigA, busyA, doneA;
  logic [6:0] dataB;
  logic       actB;
  logic       sigB, busyB, doneB;

  int checkCount = 0;
  int passCount  = 0;

  always #5 clock = ~clock;

  uart_tx_frame #(
    .DATA_BITS(8), .CLKS_PER_BIT(CPB), .STOP_BITS(1), .PARITY_ODD(0)
  ) dutA (
    .i_clock(clock), .i_reset(reset), .i_data(dataA), .i_act(actA),
    .o_signal(sigA), .o_busy(busyA), .o_done(doneA)
  );

  uart_tx_frame #(
    .DATA_BITS(7), .CLKS_PER_BIT(CPB), .STOP_BITS(2), .PARITY_ODD(1)
  ) dutB (
    .i_clock(clock), .i_reset(reset), .i_data(dataB), .i_act(actB),
    .o_signal(sigB), .o_busy(busyB), .o_done(doneB)
  );

  // Single comparison point: counts every check and reports mismatches
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Model of the line: bit 0 of bits is the first bit sent
  task automatic buildFrame(input logic [8:0] word, input int dataBits,
                            input int stopBits, input bit parOdd,
                            output logic [15:0] bits, output int nbits);
    bit par;
    bits  = '1;
    nbits = 0;
    par   = parOdd;
    bits[nbits] = 1'b0;
    nbits++;
    for (int i = 0; i < dataBits; i++) begin
      bits[nbits] = word[i];
      par = par ^ word[i];
      nbits++;
    end
`ifdef UART_TX_PARITY_EN
    bits[nbits] = par;
    nbits++;
`endif
    for (int s = 0; s < stopBits; s++) begin
      bits[nbits] = 1'b1;
      nbits++;
    end
  endtask

  // Raise the request at a falling edge, let the next rising edge accept it
  // and return in cycle 1 of the frame; the request is dropped unless held
  task automatic applyStimulus(input int sel, input logic [7:0] word, input bit hold);
    if (sel == 0) begin
      dataA = word;
      actA  = 1'b1;
    end else begin
      dataB = word[6:0];
      actB  = 1'b1;
    end
    @(posedge clock);
    @(negedge clock);
    if (!hold) begin
      actA = 1'b0;
      actB = 1'b0;
    end
  endtask

  // Called in cycle 1 of a frame; walks cycles 1..F and stops in cycle F+1
  task automatic checkFrame(input int sel, input logic [8:0] word, input int expF,
                            input string tag);
    logic [15:0] bits;
    int          nbits;
    int          busyCycles;
    logic        s, b, d;
    if (sel == 0) buildFrame(word, 8, 1, 1'b0, bits, nbits);
    else          buildFrame(word, 7, 2, 1'b1, bits, nbits);
    busyCycles = 0;
    for (int c = 0; c < nbits * CPB; c++) begin
      s = (sel == 0) ? sigA  : sigB;
      b = (sel == 0) ? busyA : busyB;
      d = (sel == 0) ? doneA : doneB;
      checkOutput($sformatf("%s_sig_c%0d", tag, c + 1), s, bits[c / CPB]);
      checkOutput($sformatf("%s_done_c%0d", tag, c + 1), d, 1'b0);
      if (b) busyCycles++;
      @(negedge clock);
    end
    checkOutput({tag, "_busyLen"}, busyCycles, expF);
    checkOutput({tag, "_endBusy"}, (sel == 0) ? busyA : busyB, 1'b0);
    checkOutput({tag, "_endDone"}, (sel == 0) ? doneA : doneB, 1'b1);
    checkOutput({tag, "_endSig"},  (sel == 0) ? sigA  : sigB,  1'b1);
  endtask

  initial begin
    reset = 1'b1;
    dataA = '0;
    actA  = 1'b0;
    dataB = '0;
    actB  = 1'b0;

    // Reset values
    #2;
    checkOutput("rstSigA",  sigA,  1'b1);
    checkOutput("rstBusyA", busyA, 1'b0);
    checkOutput("rstDoneA", doneA, 1'b0);
    checkOutput("rstSigB",  sigB,  1'b1);
    checkOutput("rstBusyB", busyB, 1'b0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    // Basic frame: 0xA5 on A
    $display("[TB] basic frame 0xA5");
    applyStimulus(0, 8'hA5, 1'b0);
    checkFrame(0, 9'h0A5, FRAME_A, "basicA5");
    @(negedge clock);
    checkOutput("basicDoneOnce", doneA, 1'b0);

    // Narrow word with two stop bits: 0x41 on B
    $display("[TB] narrow frame 0x41");
    applyStimulus(1, 8'h41, 1'b0);
    checkFrame(1, 9'h041, FRAME_B, "narrow41");
    @(negedge clock);

    // Request while busy is dropped; data changes after acceptance ignored
    $display("[TB] request while busy");
    applyStimulus(0, 8'h3C, 1'b0);
    fork
      checkFrame(0, 9'h03C, FRAME_A, "busyReq");
      begin
        repeat (9) @(negedge clock);
        dataA = 8'h12;
        actA  = 1'b1;
        @(negedge clock);
        actA  = 1'b0;
      end
    join
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      checkOutput($sformatf("noSecondBusy_%0d", i), busyA, 1'b0);
      checkOutput($sformatf("noSecondSig_%0d", i), sigA, 1'b1);
    end

    // Back-to-back with the request held: one idle cycle between frames
    $display("[TB] back-to-back 0x55 0xAA");
    applyStimulus(0, 8'h55, 1'b1);
    dataA = 8'hAA;
    checkFrame(0, 9'h055, FRAME_A, "b2b55");
    @(negedge clock);
    actA = 1'b0;
    checkOutput("b2bRestartBusy", busyA, 1'b1);
    checkFrame(0, 9'h0AA, FRAME_A, "b2bAA");
    @(negedge clock);

    // Reset during the data bits: line high and busy low at once, no done
    $display("[TB] reset mid-frame");
    applyStimulus(0, 8'hA5, 1'b0);
    repeat (17) @(negedge clock);
    checkOutput("preRstSig",  sigA,  1'b0);
    checkOutput("preRstBusy", busyA, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("midRstSig",  sigA,  1'b1);
    checkOutput("midRstBusy", busyA, 1'b0);
    checkOutput("midRstDone", doneA, 1'b0);
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      checkOutput($sformatf("postRstDone_%0d", i), doneA, 1'b0);
      checkOutput($sformatf("postRstBusy_%0d", i), busyA, 1'b0);
    end
    applyStimulus(0, 8'h3C, 1'b0);
    checkFrame(0, 9'h03C, FRAME_A, "afterRst");
    @(negedge clock);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/uart_tx_frame.md
# uart_tx_frame

Parametrised UART transmitter: the successor to the fixed 8-bit, handshake-only transmitter.
- Serialises a parallel word into a complete asynchronous frame on `o_signal`: start bit, configurable data bits LSB first, optional parity, 1 or 2 stop bits.
- Each bit is held for a programmed number of clocks.
- Sits between any byte producer (command FSM, FIFO read side) and the board TX pin.
- Keeps the existing `i_act`/`o_busy` handshake, so producers need no changes.

## Interface
- `DATA_BITS`, 8, data bits per frame; legal 5..9.
- `CLKS_PER_BIT`, 16, `i_clock` cycles per serial bit; legal ≥2.
- `STOP_BITS`, 1, stop bits per frame; legal 1 or 2.
- `PARITY_ODD`, 0, 0 = even parity, 1 = odd parity; only meaningful with `UART_TX_PARITY_EN`.
- `i_clock`  input  1  the block's only clock; all logic is on the rising edge.
- `i_reset`  input  1  asynchronous, active-high reset.
- `i_data`  input  DATA_BITS  word to send; sampled only on acceptance.
- `i_act`  input  1  send request.
- `o_signal`  output  1  serial line; idle high.
- `o_busy`  output  1  frame in progress; requests are ignored while high.
- `o_done`  output  1  one-cycle pulse when a frame completes.

## Operation
- Reset values (asynchronous, take effect immediately):
  - `o_signal`=1, `o_busy`=0, `o_done`=0.
  - State = IDLE; bit counter and baud counter = 0.
- Acceptance: at a rising edge where `i_act`=1 and `o_busy`=0, `i_data` is latched into the shift register and the state goes to START.
- No pending request is queued. A request while `o_busy`=1 is dropped; the producer must hold `i_act`.
- States:
  - IDLE: `o_signal`=1.
  - START: `o_signal`=0 for one bit time.
  - DATA: `o_signal`=shift[0]. Shift right after each bit time. After DATA_BITS bits, go to PARITY if enabled, else STOP.
  - PARITY: `o_signal` = XOR of the latched word, XORed with `PARITY_ODD`.
  - STOP: `o_signal`=1 for STOP_BITS bit times, then IDLE.
- Bit time: the baud counter counts 0..CLKS_PER_BIT-1. A bit ends when the counter is at CLKS_PER_BIT-1. The counter restarts at 0 on every state or bit change.
- Widths:
  - Baud counter: $clog2(CLKS_PER_BIT) bits.
  - Bit counter: $clog2(DATA_BITS+1) bits.
  - No counter may wrap mid-bit.
- `i_reset` asserted mid-frame aborts the frame. The line returns high at once and no `o_done` pulse is produced.
- Changes on `i_data` after acceptance have no effect on the frame in flight.

## Timing
- Acceptance edge = cycle 0. From cycle 1: `o_busy`=1 and `o_signal`=0 (start bit).
- Frame length F = (1 + DATA_BITS + P + STOP_BITS) × CLKS_PER_BIT cycles, where P=1 if parity is compiled in, else 0.
- `o_busy` is high for exactly F cycles (cycles 1..F).
- In cycle F+1: `o_busy`=0 and `o_done`=1 for that single cycle. A new request can be accepted at the edge ending cycle F+1.
- Back-to-back with `i_act` held high: exactly one idle-high cycle between frames.
- All outputs are registered; no combinational path from inputs to outputs.

## Configuration
- Macro: `UART_TX_PARITY_EN`.
- Defined: the PARITY state exists, P=1, and `PARITY_ODD` selects the polarity.
- Undefined: no PARITY state, P=0, and `PARITY_ODD` is ignored. DATA goes directly to STOP.

## Structure
- Shared package `uart_pkg`:
  - State enum `uart_tx_state_t` (IDLE, START, DATA, PARITY, STOP).
  - Line levels `UART_IDLE`=1 and `UART_START`=0.
  - Legal-range limits for the parameters.
- Sub-module `uart_baud_tick`, parametrised by CLKS_PER_BIT:
  - Inputs: `i_clock`, `i_reset`, synchronous clear.
  - Output: one-cycle `o_tick` at CLKS_PER_BIT-1.
  - The receiver reuses it.
- Elaboration-time check rejects illegal parameter values.

## Test plan
- **Basic frame.** DATA_BITS=8, CLKS_PER_BIT=4, parity off, send 0xA5.
  - `o_signal` per 4-cycle bit: 0, 1,0,1,0,0,1,0,1, 1.
  - `o_busy` high 40 cycles; `o_done` pulses at cycle 41.
- **Even parity.** Parity on, PARITY_ODD=0, send 0xA5: parity bit = 0, F=44. With PARITY_ODD=1, parity bit = 1.
- **Narrow word, two stops.** DATA_BITS=7, STOP_BITS=2, send 0x41.
  - Bits: 0, 1,0,0,0,0,0,1, 1,1.
  - F=40 with CLKS_PER_BIT=4.
- **Request while busy.** Pulse `i_act` with 0x12 mid-frame: ignored, and no second frame follows.
- **Back-to-back.** Hold `i_act` high with 0x55 then 0xAA: two frames separated by exactly one idle-high cycle.
- **Reset mid-frame.** Assert `i_reset` during the DATA state.
  - `o_signal`=1 and `o_busy`=0 asynchronously, with no `o_done`.
  - After release, the next frame is correct.
